// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and helpers for the 4x4 keypad scanner.
//   state_e    : debounce FSM state (IDLE, PRESSED)
//   scan_res_e : classification of one full sweep (NONE, SINGLE, MULTI)
//   count_low  : number of active-low rows in one column sample
//   first_low  : index of the lowest active-low row in one column sample
package keypad_pkg;

  typedef enum logic {IDLE, PRESSED} state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_e;

  localparam int          NUM_COLS  = 4;
  localparam int          NUM_ROWS  = 4;
  localparam int          CODE_W    = 4;
  localparam logic [3:0]  COL_RESET = 4'b1110;

  function automatic logic [2:0] count_low(input logic [NUM_ROWS-1:0] rows_n);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_ROWS; i++) n = n + 3'(!rows_n[i]);
    return n;
  endfunction

  function automatic logic [1:0] first_low(input logic [NUM_ROWS-1:0] rows_n);
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_ROWS-1; i >= 0; i--) if (!rows_n[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: W-bit two-flop synchronizer for asynchronous inputs.
//   clk, rst_n : clock, async active-low reset (flops reset to all-ones,
//                matching idle pulled-up keypad rows)
//   d          : asynchronous input
//   q          : synchronized output
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: 4x4 matrix keypad scanner with debounce and a 4-digit
// nibble history register for a multiplexed display.
//   clk, rst_n : clock, async active-low reset
//   row_n      : raw keypad rows, active-low, asynchronous
//   clr        : synchronous clear of key_data
//   col_n      : active-low one-hot column drive
//   key_code   : last accepted key code {row, col}
//   key_valid  : one-cycle pulse when a press is accepted
//   key_down   : high while an accepted key is held
//   key_data   : last four accepted codes, newest in [3:0]
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_n,
  input  logic                clr,
  output logic [NUM_COLS-1:0] col_n,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_down,
  output logic [15:0]         key_data
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
  localparam int COL_W = $clog2(NUM_COLS);

  logic [NUM_ROWS-1:0]   row_s;
  logic [SCAN_DIV_W-1:0] div;
  logic [COL_W-1:0]      col_idx;
  logic [1:0]            hit_acc;   // intersections seen this sweep, saturating at 2
  logic [CODE_W-1:0]     code_acc;  // code of the first single intersection
  logic [CODE_W-1:0]     cand;
  logic [3:0]            press_cnt;
  logic [3:0]            rel_cnt;
  state_e                state;

  keypad_sync #(.W(NUM_ROWS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (row_s)
  );

  logic              div_max, sweep_end;
  logic [2:0]        col_hits, hit_sum;
  logic [1:0]        hits_nx;
  logic [CODE_W-1:0] code_nx;
  scan_res_e         sweep_res;
  logic [3:0]        press_nx, rel_nx;

  always_comb begin
    div_max   = &div;
    sweep_end = div_max && (col_idx == COL_W'(NUM_COLS-1));
    col_hits  = count_low(row_s);
    hit_sum   = {1'b0, hit_acc} + col_hits;
    hits_nx   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    code_nx   = code_acc;
    if (hit_acc == 2'd0 && col_hits == 3'd1) code_nx = {first_low(row_s), col_idx};
    case (hits_nx)
      2'd0:    sweep_res = NONE;
      2'd1:    sweep_res = SINGLE;
      default: sweep_res = MULTI;
    endcase
    // a repeat of the current candidate extends the run, anything else restarts it
    press_nx = (code_nx == cand) ? press_cnt + 4'd1 : 4'd1;
    rel_nx   = rel_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      col_idx   <= '0;
      col_n     <= COL_RESET;
      hit_acc   <= '0;
      code_acc  <= '0;
      cand      <= '0;
      press_cnt <= '0;
      rel_cnt   <= '0;
      state     <= IDLE;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      key_data  <= '0;
    end else begin
      key_valid <= 1'b0;
      div       <= div + 1'b1;
      if (clr) key_data <= '0;
      if (div_max) begin
        col_idx <= col_idx + 1'b1;
        col_n   <= {col_n[NUM_COLS-2:0], col_n[NUM_COLS-1]};
        if (!sweep_end) begin
          hit_acc  <= hits_nx;
          code_acc <= code_nx;
        end else begin
          hit_acc  <= '0;
          code_acc <= '0;
          case (state)
            IDLE: begin
              if (sweep_res == SINGLE) begin
                cand <= code_nx;
                if (press_nx >= DEB) begin
                  state     <= PRESSED;
                  press_cnt <= '0;
                  rel_cnt   <= '0;
                  key_code  <= code_nx;
                  key_valid <= 1'b1;
                  key_down  <= 1'b1;
                  // acceptance wins over a coincident clear: only the new code survives
                  key_data  <= clr ? {12'h000, code_nx} : {key_data[11:0], code_nx};
                end else begin
                  press_cnt <= press_nx;
                end
              end else begin
                press_cnt <= '0;
              end
            end
            PRESSED: begin
              if (sweep_res == NONE) begin
                if (rel_nx >= DEB) begin
                  state     <= IDLE;
                  key_down  <= 1'b0;
                  press_cnt <= '0;
                  rel_cnt   <= '0;
                end else begin
                  rel_cnt <= rel_nx;
                end
              end else begin
                rel_cnt <= '0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
